// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared game definitions: enemy slot states, spawn point locations and small
// bit-vector helpers used by the spawn scheduler.
package enemy_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        ALIVE      = 2'd0,
        DYING      = 2'd1,
        WAIT_SPAWN = 2'd2,
        DEAD       = 2'd3
    } slot_state_e;

    // Spawn point pixel coordinates along the top edge of the playfield.
    localparam int         MAX_SPAWN = 3;
    localparam logic [9:0] SPAWN_X [MAX_SPAWN] = '{10'd16, 10'd304, 10'd592};
    localparam logic [9:0] SPAWN_Y [MAX_SPAWN] = '{10'd16, 10'd16, 10'd16};

    function automatic logic [7:0] popcount32(input logic [31:0] v);
        popcount32 = '0;
        for (int i = 0; i < 32; i++) begin
            popcount32 = popcount32 + {7'd0, v[i]};
        end
    endfunction

    function automatic int onehot_idx(input logic [31:0] oh);
        onehot_idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) onehot_idx = i;
        end
    endfunction

endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// Frame-level control and status bundle between the game core and the
// enemy spawn scheduler.
interface enemy_spawn_scheduler_if #(
    parameter int NUM_ENEMY = 4,
    parameter int NUM_SPAWN = 3
);
    localparam int SEL_W = (NUM_SPAWN > 1) ? $clog2(NUM_SPAWN) : 1;

    logic                 refresh_tick;
    logic [NUM_ENEMY-1:0] enemy_destroyed;
    logic [NUM_SPAWN-1:0] spawn_blocked;
    logic                 game_over;
    logic [NUM_ENEMY-1:0] enemy_alive;
    logic [NUM_ENEMY-1:0] spawn_req;
    logic [SEL_W-1:0]     spawn_sel;
    logic [7:0]           enemies_left;
    logic                 wave_done;

    modport master (
        output refresh_tick, enemy_destroyed, spawn_blocked, game_over,
        input  enemy_alive, spawn_req, spawn_sel, enemies_left, wave_done
    );

    modport slave (
        input  refresh_tick, enemy_destroyed, spawn_blocked, game_over,
        output enemy_alive, spawn_req, spawn_sel, enemies_left, wave_done
    );
endinterface

// File: rtl/enemy_spawn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the index just
// after ptr and wraps; the first requester found gets a one-hot grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand[IW-1:0]]) begin
                found               = 1'b1;
                gnt[cand[IW-1:0]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy wave scheduler: per-slot kill/respawn lifecycle, respawn countdown,
// round-robin slot and spawn point grants, and wave bookkeeping.
module enemy_spawn_scheduler
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter int NUM_ENEMY     = 4,
    parameter int NUM_SPAWN     = 3,
    parameter int TOTAL_ENEMIES = 20,
    parameter int RESPAWN_DELAY = 64
) (
    input  logic                     clk_50MHz,
    input  logic                     reset,
    enemy_spawn_scheduler_if.slave   bus
);
    localparam int SLOT_W = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
    localparam int SEL_W  = (NUM_SPAWN > 1) ? $clog2(NUM_SPAWN) : 1;
    localparam int CNT_W  = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(RESPAWN_DELAY - 1);
    localparam logic [7:0]       RESERVE_INIT = 8'(TOTAL_ENEMIES - NUM_ENEMY);
    localparam logic [7:0]       LEFT_INIT    = 8'(TOTAL_ENEMIES);

    slot_state_e       state_q [NUM_ENEMY];
    slot_state_e       state_d [NUM_ENEMY];
    logic [CNT_W-1:0]  cnt_q   [NUM_ENEMY];
    logic [CNT_W-1:0]  cnt_d   [NUM_ENEMY];
    logic [7:0]        reserve_q, reserve_d;
    logic [7:0]        left_q, left_d;
    logic [SLOT_W-1:0] slot_ptr_q, slot_ptr_d;
    logic [SEL_W-1:0]  pt_ptr_q, pt_ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic                 advance;
    logic                 grant;
    logic                 all_dead;
    logic [NUM_ENEMY-1:0] alive;
    logic [NUM_ENEMY-1:0] waiting;
    logic [NUM_ENEMY-1:0] kill;
    logic [NUM_ENEMY-1:0] slot_gnt;
    logic [NUM_SPAWN-1:0] pt_gnt;
    logic [SLOT_W-1:0]    slot_idx;
    logic [SEL_W-1:0]     pt_idx;
    logic [7:0]           kill_cnt;

    // Reset is folded in so an in-flight grant cannot pulse spawn_req.
    assign advance = bus.refresh_tick & ~bus.game_over & ~reset;

    always_comb begin
        alive    = '0;
        waiting  = '0;
        all_dead = 1'b1;
        for (int i = 0; i < NUM_ENEMY; i++) begin
            alive[i]   = (state_q[i] == ALIVE);
            waiting[i] = (state_q[i] == WAIT_SPAWN) && (reserve_q != '0);
            if (state_q[i] != DEAD) all_dead = 1'b0;
        end
    end

    rr_arbiter #(.N(NUM_ENEMY), .IW(SLOT_W)) u_slot_arb (
        .req (waiting),
        .ptr (slot_ptr_q),
        .gnt (slot_gnt)
    );

    rr_arbiter #(.N(NUM_SPAWN), .IW(SEL_W)) u_point_arb (
        .req (~bus.spawn_blocked),
        .ptr (pt_ptr_q),
        .gnt (pt_gnt)
    );

    assign grant    = advance & (|slot_gnt) & (|pt_gnt);
    assign slot_idx = SLOT_W'(onehot_idx(32'(slot_gnt)));
    assign pt_idx   = SEL_W'(onehot_idx(32'(pt_gnt)));
    assign kill     = advance ? (bus.enemy_destroyed & alive) : '0;
    assign kill_cnt = popcount32(32'(kill));

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                state_q[i] <= ALIVE;
                cnt_q[i]   <= '0;
            end
            reserve_q  <= RESERVE_INIT;
            left_q     <= LEFT_INIT;
            slot_ptr_q <= SLOT_W'(NUM_ENEMY - 1);
            pt_ptr_q   <= SEL_W'(NUM_SPAWN - 1);
            sel_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            reserve_q  <= reserve_d;
            left_q     <= left_d;
            slot_ptr_q <= slot_ptr_d;
            pt_ptr_q   <= pt_ptr_d;
            sel_q      <= sel_d;
        end
    end

    always_comb begin
        reserve_d  = reserve_q;
        left_d     = left_q;
        slot_ptr_d = slot_ptr_q;
        pt_ptr_d   = pt_ptr_q;
        sel_d      = sel_q;
        for (int i = 0; i < NUM_ENEMY; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (advance) begin
                unique case (state_q[i])
                    ALIVE: begin
                        if (bus.enemy_destroyed[i]) begin
                            state_d[i] = DYING;
                            cnt_d[i]   = CNT_LOAD;
                        end
                    end
                    // Leaving on the tick that reaches 0 makes the grant land
                    // exactly RESPAWN_DELAY ticks after the kill.
                    DYING: begin
                        if (cnt_q[i] <= CNT_W'(1)) begin
                            cnt_d[i]   = '0;
                            state_d[i] = (reserve_q != '0) ? WAIT_SPAWN : DEAD;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                    end
                    WAIT_SPAWN: begin
                        if (grant && slot_gnt[i]) state_d[i] = ALIVE;
                        else if (reserve_q == '0) state_d[i] = DEAD;
                    end
                    default: ;
                endcase
            end
        end
        if (advance) begin
            left_d = (kill_cnt >= left_q) ? 8'd0 : (left_q - kill_cnt);
        end
        if (grant) begin
            reserve_d  = reserve_q - 8'd1;
            slot_ptr_d = slot_idx;
            pt_ptr_d   = pt_idx;
            sel_d      = pt_idx;
        end
    end

    always_comb begin
        bus.enemy_alive  = alive;
        bus.spawn_req    = grant ? slot_gnt : '0;
        bus.spawn_sel    = grant ? pt_idx : sel_q;
        bus.enemies_left = left_q;
        bus.wave_done    = (left_q == 8'd0) && all_dead;
    end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Bench for enemy_spawn_scheduler: timestamp-based wave model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_enemy_spawn_scheduler;
    localparam int NE    = 4;
    localparam int NS    = 3;
    localparam int DELAY = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    enemy_spawn_scheduler_if #(.NUM_ENEMY(NE), .NUM_SPAWN(NS)) bus ();
    enemy_spawn_scheduler_if #(.NUM_ENEMY(NE), .NUM_SPAWN(NS)) bus2 ();

    enemy_spawn_scheduler #(.NUM_ENEMY(NE), .NUM_SPAWN(NS), .TOTAL_ENEMIES(20),
                            .RESPAWN_DELAY(DELAY)) dut (
        .clk_50MHz (clk),
        .reset     (rst),
        .bus       (bus.slave)
    );

    enemy_spawn_scheduler #(.NUM_ENEMY(NE), .NUM_SPAWN(NS), .TOTAL_ENEMIES(4),
                            .RESPAWN_DELAY(DELAY)) dut2 (
        .clk_50MHz (clk),
        .reset     (rst),
        .bus       (bus2.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a killed slot becomes eligible DELAY effective ticks after the kill.
    bit m_alive [NE];
    bit m_dead  [NE];
    int m_elig  [NE];
    int m_left, m_reserve, m_last_slot, m_last_pt, m_sel, m_tick;

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_alive[i] = 1'b1; m_dead[i] = 1'b0; m_elig[i] = 0;
        end
        m_left = 20; m_reserve = 16; m_last_slot = NE - 1; m_last_pt = NS - 1;
        m_sel = 0; m_tick = 0;
    endtask

    logic [NE-1:0] e_req, e_alive;
    int  e_sel, ws, wp, c;
    bit  e_done, eff;

    always @(negedge clk) begin
        if (rst) model_reset();
        eff = bus.refresh_tick && !bus.game_over && !rst;
        ws = -1; wp = -1;
        if (eff && m_reserve > 0) begin
            for (int off = 1; off <= NE; off++) begin
                c = (m_last_slot + off) % NE;
                if (ws < 0 && !m_alive[c] && !m_dead[c] && m_tick >= m_elig[c]) ws = c;
            end
            for (int off = 1; off <= NS; off++) begin
                c = (m_last_pt + off) % NS;
                if (wp < 0 && !bus.spawn_blocked[c]) wp = c;
            end
            if (ws < 0 || wp < 0) begin ws = -1; wp = -1; end
        end
        e_req = '0; e_alive = '0; e_done = (m_left == 0);
        if (ws >= 0) e_req[ws] = 1'b1;
        e_sel = (ws >= 0) ? wp : m_sel;
        for (int i = 0; i < NE; i++) begin
            e_alive[i] = m_alive[i];
            if (!m_dead[i]) e_done = 1'b0;
        end
        chk("m_alive", bus.enemy_alive, e_alive);
        chk("m_spawn_req", bus.spawn_req, e_req);
        chk("m_spawn_sel", bus.spawn_sel, e_sel);
        chk("m_left", bus.enemies_left, m_left);
        chk("m_wave_done", bus.wave_done, e_done);
        if (eff) begin
            for (int i = 0; i < NE; i++)
                if (!m_alive[i] && !m_dead[i] && i != ws && m_tick >= m_elig[i] - 1 && m_reserve == 0)
                    m_dead[i] = 1'b1;
            for (int i = 0; i < NE; i++)
                if (m_alive[i] && bus.enemy_destroyed[i]) begin
                    m_alive[i] = 1'b0;
                    m_elig[i]  = m_tick + DELAY;
                    if (m_left > 0) m_left--;
                end
            if (ws >= 0) begin
                m_alive[ws] = 1'b1; m_reserve--; m_last_slot = ws; m_last_pt = wp; m_sel = wp;
            end
            m_tick++;
        end
    end

    logic [NE-1:0] cap_req, cap2_req;
    logic [1:0]    cap_sel;
    logic [7:0]    cap_left;

    task automatic do_tick(input logic [NE-1:0] kill);
        bus.refresh_tick = 1'b1; bus.enemy_destroyed = kill;
        @(negedge clk);
        cap_req = bus.spawn_req; cap_sel = bus.spawn_sel; cap_left = bus.enemies_left;
        @(posedge clk); #1;
        bus.refresh_tick = 1'b0; bus.enemy_destroyed = '0;
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick('0);
    endtask

    task automatic do_tick2(input logic [NE-1:0] kill);
        bus2.refresh_tick = 1'b1; bus2.enemy_destroyed = kill;
        @(negedge clk);
        cap2_req = bus2.spawn_req;
        @(posedge clk); #1;
        bus2.refresh_tick = 1'b0; bus2.enemy_destroyed = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.refresh_tick = 1'b0;  bus.enemy_destroyed = '0;  bus.spawn_blocked = '0;  bus.game_over = 1'b0;
        bus2.refresh_tick = 1'b0; bus2.enemy_destroyed = '0; bus2.spawn_blocked = '0; bus2.game_over = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_alive", bus.enemy_alive, 4'hF);
        chk("rst_left", bus.enemies_left, 20);
        chk("rst_sel", bus.spawn_sel, 0);
        chk("rst_done", bus.wave_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // single kill, respawn after 64 ticks
        do_tick(4'b0001);
        chk("a_left_kill", bus.enemies_left, 19);
        chk("a_alive_kill", bus.enemy_alive, 4'b1110);
        ticks(63);
        chk("a_req_early", cap_req, 4'b0000);
        do_tick('0);
        chk("a_req", cap_req, 4'b0001);
        chk("a_sel", cap_sel, 0);
        chk("a_left", cap_left, 19);
        chk("a_reserve", dut.reserve_q, 15);
        chk("a_alive", bus.enemy_alive, 4'hF);

        // double kill, then a kill on a dying slot that must be ignored
        do_tick(4'b0110);
        chk("b_left", bus.enemies_left, 17);
        do_tick(4'b0010);
        chk("b_left_ignored", bus.enemies_left, 17);
        ticks(62);
        do_tick('0);
        chk("b_req1", cap_req, 4'b0010);
        chk("b_sel1", cap_sel, 1);
        do_tick('0);
        chk("b_req2", cap_req, 4'b0100);
        chk("b_sel2", cap_sel, 2);
        chk("b_reserve", dut.reserve_q, 13);

        // all spawn points blocked, then point 2 freed
        bus.spawn_blocked = 3'b111;
        do_tick(4'b0001);
        ticks(63);
        do_tick('0);
        chk("c_req_blocked", cap_req, 4'b0000);
        chk("c_sel_held", cap_sel, 2);
        do_tick('0);
        chk("c_req_blocked2", cap_req, 4'b0000);
        bus.spawn_blocked = 3'b011;
        do_tick('0);
        chk("c_req", cap_req, 4'b0001);
        chk("c_sel", cap_sel, 2);
        bus.spawn_blocked = 3'b000;
        chk("c_sel_hold_after", bus.spawn_sel, 2);

        // game_over freeze during a countdown
        do_tick(4'b1000);
        ticks(10);
        bus.game_over = 1'b1;
        repeat (100) do_tick(4'b0001);
        chk("d_left_frozen", bus.enemies_left, 15);
        chk("d_alive_frozen", bus.enemy_alive, 4'b0111);
        chk("d_cnt_frozen", dut.cnt_q[3], 53);
        bus.game_over = 1'b0;
        ticks(53);
        chk("d_req_early", cap_req, 4'b0000);
        do_tick('0);
        chk("d_req", cap_req, 4'b1000);
        chk("d_sel", cap_sel, 0);

        // reset while a slot waits and a grant is about to fire
        bus.spawn_blocked = 3'b111;
        do_tick(4'b0010);
        ticks(64);
        chk("e_req_blocked", cap_req, 4'b0000);
        bus.spawn_blocked = 3'b000;
        bus.refresh_tick = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("e_req_in_reset", bus.spawn_req, 4'b0000);
        chk("e_alive_reset", bus.enemy_alive, 4'hF);
        chk("e_left_reset", bus.enemies_left, 20);
        @(posedge clk); #1;
        rst = 1'b0; bus.refresh_tick = 1'b0;
        @(posedge clk); #1;
        do_tick('0);
        chk("e_req_after", cap_req, 4'b0000);
        chk("e_left_after", bus.enemies_left, 20);

        // small wave: kill all four with no reserve
        do_tick2(4'hF);
        chk("f_left", bus2.enemies_left, 0);
        chk("f_done_kill", bus2.wave_done, 0);
        repeat (62) do_tick2('0);
        chk("f_done_early", bus2.wave_done, 0);
        do_tick2('0);
        chk("f_alive", bus2.enemy_alive, 4'h0);
        chk("f_left_end", bus2.enemies_left, 0);
        chk("f_done", bus2.wave_done, 1);
        do_tick2('0);
        chk("f_req", cap2_req, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
